// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter built from a bank of T-type cells.
// tc supports cascading. wrap, load_err and toggle are registered debug/status pulses.

module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else       q <= q ^ t;
  end
endmodule

module tff_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err,
  output logic [WIDTH-1:0] toggle
);
  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  if (WIDTH < 2 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
    $fatal(1, "tff_mod_counter: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] up_vec;
  logic [WIDTH-1:0] dn_vec;
  logic             wrap_next;
  logic             err_next;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count == MAX);
  assign at_zero = (count == '0);
  assign tc      = en & ~load & (up ? at_max : at_zero);

  // Prefix AND chains: bit i toggles once all lower bits are at 1 (up) or 0 (down).
  always_comb begin
    up_vec    = '0;
    dn_vec    = '0;
    up_vec[0] = 1'b1;
    dn_vec[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      up_vec[i] = up_vec[i-1] & count[i-1];
      dn_vec[i] = dn_vec[i-1] & ~count[i-1];
    end
  end

  // Every next value is reached as count ^ t, including loads and wraps.
  always_comb begin
    t         = '0;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (reset) begin
      t = '0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        t = count ^ load_val;
      end else begin
        t        = count ^ MAX;
        err_next = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          t         = count;
          wrap_next = 1'b1;
        end else begin
          t = up_vec;
        end
      end else begin
        if (at_zero) begin
          t         = MAX;
          wrap_next = 1'b1;
        end else begin
          t = dn_vec;
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (t[g]),
      .q     (count[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      toggle   <= '0;
    end else begin
      wrap     <= wrap_next;
      load_err <= err_next;
      toggle   <= t;
    end
  end
endmodule

// File: tb/tb_tff_mod_counter.sv
// Bench for tff_mod_counter: arithmetic modulo model, directed literal checks, random stimulus.
module tb_tff_mod_counter;
  localparam int NK = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;

  function automatic int mod_of(input int k);
    case (k)
      0:       return 10;
      1:       return 8;
      default: return 5;
    endcase
  endfunction

  function automatic int width_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Standalone instances: k=0 W4/M10, k=1 W3/M8, k=2 W3/M5
  logic       r[NK], e[NK], u[NK], ld[NK];
  logic [3:0] lv[NK];
  logic [3:0] q_cnt[NK], q_tog[NK];
  logic       q_wrap[NK], q_err[NK], q_tc[NK];
  logic [2:0] c8, t8, c5, t5;

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_d10 (
    .clk(clk), .reset(r[0]), .en(e[0]), .up(u[0]), .load(ld[0]), .load_val(lv[0]),
    .count(q_cnt[0]), .tc(q_tc[0]), .wrap(q_wrap[0]), .load_err(q_err[0]), .toggle(q_tog[0]));

  tff_mod_counter #(.WIDTH(3), .MODULUS(8)) u_d8 (
    .clk(clk), .reset(r[1]), .en(e[1]), .up(u[1]), .load(ld[1]), .load_val(lv[1][2:0]),
    .count(c8), .tc(q_tc[1]), .wrap(q_wrap[1]), .load_err(q_err[1]), .toggle(t8));

  tff_mod_counter #(.WIDTH(3), .MODULUS(5)) u_d5 (
    .clk(clk), .reset(r[2]), .en(e[2]), .up(u[2]), .load(ld[2]), .load_val(lv[2][2:0]),
    .count(c5), .tc(q_tc[2]), .wrap(q_wrap[2]), .load_err(q_err[2]), .toggle(t5));

  assign q_cnt[1] = {1'b0, c8};
  assign q_tog[1] = {1'b0, t8};
  assign q_cnt[2] = {1'b0, c5};
  assign q_tog[2] = {1'b0, t5};

  // Two-stage decimal cascade
  logic       cr, ce, cu;
  logic [3:0] uc, tcnt, utog, ttog;
  logic       utc, ttc, uwrap, twrap, uerr, terr;

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_units (
    .clk(clk), .reset(cr), .en(ce), .up(cu), .load(1'b0), .load_val(4'd0),
    .count(uc), .tc(utc), .wrap(uwrap), .load_err(uerr), .toggle(utog));

  tff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_tens (
    .clk(clk), .reset(cr), .en(utc), .up(cu), .load(1'b0), .load_val(4'd0),
    .count(tcnt), .tc(ttc), .wrap(twrap), .load_err(terr), .toggle(ttog));

  // Reference model: plain modulo arithmetic on integers
  int   m_cnt[NK];
  int   m_tog[NK];
  logic m_wrap[NK], m_err[NK];
  bit   m_ok[NK];
  int   mv;
  logic mw_u, mw_t;
  bit   mc_ok;

  function automatic void step(input int m, input int c, input logic rs, input logic l,
                               input logic en_i, input logic up_i, input int lval,
                               output int nc, output logic w, output logic le);
    nc = c; w = 1'b0; le = 1'b0;
    if (rs) nc = 0;
    else if (l) begin
      if (lval < m) nc = lval;
      else begin nc = m - 1; le = 1'b1; end
    end else if (en_i) begin
      if (up_i) begin nc = (c + 1) % m;     w = (c == m - 1); end
      else      begin nc = (c + m - 1) % m; w = (c == 0);     end
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NK; k++) begin
      int nc; logic w, le; int lval;
      lval = int'(lv[k]) & ((1 << width_of(k)) - 1);
      step(mod_of(k), m_cnt[k], r[k], ld[k], e[k], u[k], lval, nc, w, le);
      m_cnt[k]  <= nc;
      m_wrap[k] <= w;
      m_err[k]  <= le;
      m_tog[k]  <= r[k] ? 0 : (m_cnt[k] ^ nc);
      if (r[k]) m_ok[k] <= 1'b1;
    end
    if (cr) begin
      mv <= 0; mw_u <= 1'b0; mw_t <= 1'b0; mc_ok <= 1'b1;
    end else if (ce) begin
      if (cu) begin mv <= (mv + 1) % 100;  mw_u <= (mv % 10 == 9); mw_t <= (mv == 99); end
      else    begin mv <= (mv + 99) % 100; mw_u <= (mv % 10 == 0); mw_t <= (mv == 0);  end
    end else begin
      mw_u <= 1'b0; mw_t <= 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) begin
      if (m_ok[k]) begin
        int m; logic tce;
        m   = mod_of(k);
        tce = e[k] & ~ld[k] & (u[k] ? (m_cnt[k] == m - 1) : (m_cnt[k] == 0));
        chk($sformatf("count[%0d]", k),    int'(q_cnt[k]), m_cnt[k]);
        chk($sformatf("wrap[%0d]", k),     int'(q_wrap[k]), int'(m_wrap[k]));
        chk($sformatf("load_err[%0d]", k), int'(q_err[k]), int'(m_err[k]));
        chk($sformatf("toggle[%0d]", k),   int'(q_tog[k]), m_tog[k]);
        chk($sformatf("tc[%0d]", k),       int'(q_tc[k]), int'(tce));
        chk($sformatf("range[%0d]", k),    int'(int'(q_cnt[k]) < m), 1);
      end
    end
    if (mc_ok) begin
      chk("casc_units", int'(uc), mv % 10);
      chk("casc_tens",  int'(tcnt), mv / 10);
      chk("casc_uwrap", int'(uwrap), int'(mw_u));
      chk("casc_twrap", int'(twrap), int'(mw_t));
      chk("casc_utc",   int'(utc), int'(ce & (cu ? (mv % 10 == 9) : (mv % 10 == 0))));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nw;
    for (int k = 0; k < NK; k++) begin
      r[k] = 1'b1; e[k] = 1'b0; u[k] = 1'b1; ld[k] = 1'b0; lv[k] = 4'd0;
    end
    cr = 1'b1; ce = 1'b0; cu = 1'b1;
    tick(); tick();
    for (int k = 0; k < NK; k++) r[k] = 1'b0;
    cr = 1'b0;
    chk("rst_count", int'(q_cnt[0]), 0);
    chk("rst_wrap",  int'(q_wrap[0]), 0);
    chk("rst_err",   int'(q_err[0]), 0);
    chk("rst_tog",   int'(q_tog[0]), 0);

    // Up count 12 cycles
    e[0] = 1'b1; u[0] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("up_seq%0d", i), int'(q_cnt[0]), i % 10);
      chk($sformatf("up_tc%0d", i), int'(q_tc[0]), (i % 10 == 9) ? 1 : 0);
      chk($sformatf("up_wrap%0d", i), int'(q_wrap[0]), (i == 10) ? 1 : 0);
      if (i == 8) chk("tog_7to8", int'(q_tog[0]), 15);
    end

    // Down from 0
    e[0] = 1'b0; ld[0] = 1'b1; lv[0] = 4'd0;
    tick();
    ld[0] = 1'b0; e[0] = 1'b1; u[0] = 1'b0;
    #1 chk("dn_tc_at0", int'(q_tc[0]), 1);
    tick();
    chk("dn_wrap_cnt", int'(q_cnt[0]), 9);
    chk("dn_wrap", int'(q_wrap[0]), 1);
    chk("dn_tc_at9", int'(q_tc[0]), 0);
    tick(); chk("dn_8", int'(q_cnt[0]), 8); chk("dn_wrap8", int'(q_wrap[0]), 0);
    tick(); chk("dn_7", int'(q_cnt[0]), 7);

    // Loads
    e[0] = 1'b0; ld[0] = 1'b1; lv[0] = 4'd6;
    tick();
    chk("ld6_cnt", int'(q_cnt[0]), 6); chk("ld6_err", int'(q_err[0]), 0); chk("ld6_wrap", int'(q_wrap[0]), 0);
    lv[0] = 4'd13;
    tick();
    chk("ld13_cnt", int'(q_cnt[0]), 9); chk("ld13_err", int'(q_err[0]), 1);
    ld[0] = 1'b0;
    tick();
    chk("ld13_err_off", int'(q_err[0]), 0); chk("ld13_hold", int'(q_cnt[0]), 9);

    // Load beats en at terminal count
    e[0] = 1'b1; u[0] = 1'b1; ld[0] = 1'b1; lv[0] = 4'd3;
    #1 chk("ldwin_tc", int'(q_tc[0]), 0);
    tick();
    chk("ldwin_cnt", int'(q_cnt[0]), 3); chk("ldwin_wrap", int'(q_wrap[0]), 0);
    ld[0] = 1'b0; e[0] = 1'b0;

    // Power-of-two modulus
    e[1] = 1'b1; u[1] = 1'b1;
    for (int i = 1; i <= 8; i++) tick();
    chk("p2_up_cnt", int'(q_cnt[1]), 0); chk("p2_up_wrap", int'(q_wrap[1]), 1); chk("p2_up_tog", int'(q_tog[1]), 7);
    u[1] = 1'b0;
    tick();
    chk("p2_dn_cnt", int'(q_cnt[1]), 7); chk("p2_dn_wrap", int'(q_wrap[1]), 1); chk("p2_dn_tog", int'(q_tog[1]), 7);
    e[1] = 1'b0;

    // Cascade 00 -> 99 -> 00, then reset at 57
    ce = 1'b1; cu = 1'b1; nw = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (twrap) nw++;
    end
    chk("casc_100_units", int'(uc), 0); chk("casc_100_tens", int'(tcnt), 0);
    chk("casc_tens_wraps", nw, 1);
    for (int i = 0; i < 57; i++) tick();
    chk("casc_57", int'(tcnt) * 10 + int'(uc), 57);
    cr = 1'b1;
    tick();
    cr = 1'b0;
    chk("casc_rst", int'(tcnt) * 10 + int'(uc), 0);
    chk("casc_rst_uwrap", int'(uwrap), 0); chk("casc_rst_twrap", int'(twrap), 0);
    tick();
    chk("casc_post_uwrap", int'(uwrap), 0); chk("casc_post_cnt", int'(uc), 1);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NK; k++) begin
        r[k]  = ($urandom_range(0, 49) == 0);
        ld[k] = ($urandom_range(0, 7) == 0);
        e[k]  = ($urandom_range(0, 3) != 0);
        u[k]  = $urandom_range(0, 1) != 0;
        lv[k] = 4'($urandom_range(0, (1 << width_of(k)) - 1));
      end
      cr = ($urandom_range(0, 199) == 0);
      ce = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) cu = ~cu;
      tick();
    end
    for (int k = 0; k < NK; k++) begin r[k] = 1'b0; e[k] = 1'b0; ld[k] = 1'b0; end
    ce = 1'b0;
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
